// File: rtl/echo_proc_pkg.sv
// Shared definitions for the echo processor: FSM states and datapath limits.
// The sign/saturation constants are sized for the 10-bit ADC/DAC sample path.
package echo_proc_pkg;

    localparam int ADDR_W_DEF = 13;
    localparam int DATA_W_DEF = 10;

    typedef enum logic [2:0] {
        S_CLEAR,
        S_IDLE,
        S_READ,
        S_CALC,
        S_WRITE
    } state_t;

    localparam logic [DATA_W_DEF-1:0]        MID_SCALE = 10'd512;
    localparam logic signed [DATA_W_DEF-1:0] SAT_MAX   = 10'sd511;
    localparam logic signed [DATA_W_DEF-1:0] SAT_MIN   = -10'sd512;

endpackage

// File: rtl/echo_proc_if.sv
// Sample-stream interface between the ADC front end, the echo processor and the DAC side.
interface echo_proc_if #(
    parameter int ADDR_W = echo_proc_pkg::ADDR_W_DEF,
    parameter int DATA_W = echo_proc_pkg::DATA_W_DEF
);
    logic [DATA_W-1:0] data_in;
    logic              data_valid;
    logic [ADDR_W-1:0] delay;
    logic [DATA_W-1:0] data_out;
    logic              out_valid;
    logic              busy;

    modport master (output data_in, data_valid, delay, input data_out, out_valid, busy);
    modport slave  (input data_in, data_valid, delay, output data_out, out_valid, busy);
endinterface

// File: rtl/echo_proc_ram.sv
// Single-port synchronous RAM holding past output samples; read-before-write, no content reset.
module echo_ram #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);
    logic [DATA_W-1:0] r_mem [2**ADDR_W];
    logic [DATA_W-1:0] r_dout;

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[addr] <= din;
        end
        r_dout <= r_mem[addr];
    end

    assign dout = r_dout;
endmodule

// File: rtl/echo_proc.sv
// Feedback echo y[n] = x[n] + y[n-D]/2 on offset-binary samples, with a circular history buffer.
// state   | meaning
// S_CLEAR | zero the whole buffer, one address per cycle
// S_IDLE  | wait for data_valid, issue the history read
// S_READ  | RAM read latency
// S_CALC  | add half the delayed sample, saturate, present data_out
// S_WRITE | store result at wr_ptr, out_valid strobe, advance wr_ptr
module echo_proc
    import echo_proc_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic sysclk,
    input  logic rst,
    echo_proc_if.slave bus
);
    state_t r_state, w_state_nxt;

    logic [ADDR_W-1:0]        r_wr_ptr, r_clr_ptr, r_delay;
    logic signed [DATA_W-1:0] r_xs, r_ys;
    logic [DATA_W-1:0]        r_data_out;

    logic                     w_we;
    logic [ADDR_W-1:0]        w_addr;
    logic [DATA_W-1:0]        w_din, w_dout;
    logic signed [DATA_W-1:0] w_ds, w_ds_half, w_ys;
    logic signed [DATA_W:0]   w_sum;

    echo_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ram (
        .clk  (sysclk),
        .we   (w_we),
        .addr (w_addr),
        .din  (w_din),
        .dout (w_dout)
    );

    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            r_state <= S_CLEAR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // The read address is held through READ so the RAM output stays valid in CALC.
    always_comb begin
        w_state_nxt = r_state;
        w_we        = 1'b0;
        w_addr      = r_wr_ptr - r_delay;
        w_din       = $unsigned(r_ys);
        case (r_state)
            S_CLEAR: begin
                w_we   = 1'b1;
                w_addr = r_clr_ptr;
                w_din  = '0;
                if (&r_clr_ptr) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_IDLE: begin
                w_addr = r_wr_ptr - bus.delay;
                if (bus.data_valid) begin
                    w_state_nxt = S_READ;
                end
            end
            S_READ:  w_state_nxt = S_CALC;
            S_CALC:  w_state_nxt = S_WRITE;
            S_WRITE: begin
                w_we        = 1'b1;
                w_addr      = r_wr_ptr;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_CLEAR;
        endcase
    end

    always_comb begin
        w_ds      = (r_delay == '0) ? '0 : $signed(w_dout);
        w_ds_half = w_ds >>> 1;
        w_sum     = {r_xs[DATA_W-1], r_xs} + {w_ds_half[DATA_W-1], w_ds_half};
        if (w_sum[DATA_W] != w_sum[DATA_W-1]) begin
            w_ys = w_sum[DATA_W] ? SAT_MIN : SAT_MAX;
        end else begin
            w_ys = w_sum[DATA_W-1:0];
        end
    end

    // data_out is loaded leaving CALC so it is already valid during the WRITE strobe.
    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_clr_ptr  <= '0;
            r_delay    <= '0;
            r_xs       <= '0;
            r_ys       <= '0;
            r_data_out <= MID_SCALE;
        end else begin
            case (r_state)
                S_CLEAR: r_clr_ptr <= r_clr_ptr + 1'b1;
                S_IDLE: begin
                    if (bus.data_valid) begin
                        r_xs    <= {~bus.data_in[DATA_W-1], bus.data_in[DATA_W-2:0]};
                        r_delay <= bus.delay;
                    end
                end
                S_CALC: begin
                    r_ys       <= w_ys;
                    r_data_out <= {~w_ys[DATA_W-1], w_ys[DATA_W-2:0]};
                end
                S_WRITE: r_wr_ptr <= r_wr_ptr + 1'b1;
                default: ;
            endcase
        end
    end

    assign bus.data_out  = r_data_out;
    assign bus.out_valid = (r_state == S_WRITE);
    assign bus.busy      = (r_state != S_IDLE);
endmodule
